// File: rtl/vlc_frame_scheduler.sv
// Read-side frame scheduler for the VLC transmit payload FIFO: preamble, header, payload, idle gap.
// Define VLC_FRAME_CHECKSUM_EN to append an XOR trailer word to each frame.
module vlc_frame_scheduler #(
    parameter int                 F_WIDTH     = 32,
    parameter int                 F_PTR_WIDTH = 10,
    parameter int                 FRAME_LEN   = 64,
    parameter logic [F_WIDTH-1:0] PREAMBLE    = 32'h5555_5555,
    parameter logic [7:0]         HDR_TAG     = 8'hC3,
    parameter int                 GAP_CYCLES  = 16,
    parameter int                 TIMEOUT     = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [F_PTR_WIDTH-1:0] fifo_data_num,
    input  logic                   fifo_empty,
    input  logic [F_WIDTH-1:0]     fifo_d_out,
    output logic                   fifo_r_en,
    output logic [F_WIDTH-1:0]     tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   tx_sof,
    output logic                   tx_eof,
    output logic                   busy,
    output logic [15:0]            frame_cnt
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
    localparam int PAD_W = F_WIDTH - 8 - F_PTR_WIDTH;
    localparam logic [F_PTR_WIDTH-1:0] FULL_LEN  = F_PTR_WIDTH'(FRAME_LEN);
    localparam logic [F_PTR_WIDTH-1:0] LEN_ONE   = F_PTR_WIDTH'(1);
    localparam logic [TMR_W-1:0]       TMR_LIMIT = TMR_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]       GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        HDR,
        PAY,
`ifdef VLC_FRAME_CHECKSUM_EN
        TRL,
`endif
        GAP
    } state_t;

    state_t                 state_q, state_d;
    logic [F_PTR_WIDTH-1:0] len_q, len_d, issued_q, sent_q, start_len;
    logic [TMR_W-1:0]       timer_q;
    logic [GAP_W-1:0]       gap_q;
    logic [F_WIDTH-1:0]     buf_mem [2];
    logic                   buf_wr_q, buf_rd_q, inflight_q;
    logic [1:0]             buf_cnt_q;
    logic                   sof_q, busy_q;
    logic [15:0]            frame_cnt_q;
    logic                   start_full, start_flush, start, gap_done, pop, push, last_word;
    logic [2:0]             occ_after;
`ifdef VLC_FRAME_CHECKSUM_EN
    logic [F_WIDTH-1:0]     csum_q;
`endif

    assign start_full  = enable && (fifo_data_num >= FULL_LEN);
    assign start_flush = enable && (fifo_data_num != '0) && (timer_q == TMR_LIMIT);
    assign start       = start_full || start_flush;
    assign start_len   = start_full ? FULL_LEN : fifo_data_num;
    assign gap_done    = (state_q == GAP) && (gap_q == GAP_LAST);
    assign push        = inflight_q;
    assign pop         = (state_q == PAY) && (buf_cnt_q != 2'd0) && tx_ready;
    assign last_word   = (sent_q == len_q - LEN_ONE);

    // A read is allowed only if the word it returns is guaranteed a buffer slot.
    assign occ_after = {1'b0, buf_cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    assign fifo_r_en = (state_q == PAY) && (issued_q < len_q) && !fifo_empty && (occ_after < 3'd2);

    assign tx_sof    = sof_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = PRE;
                    len_d   = start_len;
                end
            end
            PRE: if (tx_ready) state_d = HDR;
            HDR: if (tx_ready) state_d = PAY;
            PAY: begin
                if (pop && last_word) begin
`ifdef VLC_FRAME_CHECKSUM_EN
                    state_d = TRL;
`else
                    state_d = GAP;
`endif
                end
            end
`ifdef VLC_FRAME_CHECKSUM_EN
            TRL: if (tx_ready) state_d = GAP;
`endif
            GAP: begin
                // The last gap cycle doubles as the idle decision cycle.
                if (gap_done) begin
                    if (start) begin
                        state_d = PRE;
                        len_d   = start_len;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        tx_eof   = 1'b0;
        case (state_q)
            PRE: begin
                tx_valid = 1'b1;
                tx_data  = PREAMBLE;
            end
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = {HDR_TAG, {PAD_W{1'b0}}, len_q};
            end
            PAY: begin
                if (buf_cnt_q != 2'd0) begin
                    tx_valid = 1'b1;
                    tx_data  = buf_mem[buf_rd_q];
`ifndef VLC_FRAME_CHECKSUM_EN
                    tx_eof   = last_word;
`endif
                end
            end
`ifdef VLC_FRAME_CHECKSUM_EN
            TRL: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
                tx_eof   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            timer_q     <= '0;
            gap_q       <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            inflight_q  <= 1'b0;
            buf_wr_q    <= 1'b0;
            buf_rd_q    <= 1'b0;
            buf_cnt_q   <= 2'd0;
            sof_q       <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            sof_q      <= (state_d == PRE);
            busy_q     <= (state_d != IDLE);
            inflight_q <= fifo_r_en;

            if ((state_q == IDLE) && (state_d == IDLE) && (fifo_data_num != '0)) begin
                if (timer_q != TMR_LIMIT) timer_q <= timer_q + TMR_W'(1);
            end else begin
                timer_q <= '0;
            end

            gap_q <= (state_q == GAP) ? gap_q + GAP_W'(1) : '0;
            if (gap_done) frame_cnt_q <= frame_cnt_q + 16'd1;

            if (state_q == HDR) begin
                issued_q <= '0;
                sent_q   <= '0;
            end else begin
                if (fifo_r_en) issued_q <= issued_q + LEN_ONE;
                if (pop)       sent_q   <= sent_q + LEN_ONE;
            end

            if (push) buf_wr_q <= ~buf_wr_q;
            if (pop)  buf_rd_q <= ~buf_rd_q;
            buf_cnt_q <= buf_cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // NOTE: the data storage has no reset; buf_cnt_q (which is reset) says which entries are live.
    always_ff @(posedge clk) begin
        if (push) buf_mem[buf_wr_q] <= fifo_d_out;
    end

`ifdef VLC_FRAME_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                csum_q <= '0;
        else if (state_q == HDR)  csum_q <= '0;
        else if (pop)             csum_q <= csum_q ^ tx_data;
    end
`endif

endmodule

// File: tb/tb_vlc_frame_scheduler.sv
// Scoreboard bench for vlc_frame_scheduler: FIFO model, expected-word queue, negedge monitor.
module tb_vlc_frame_scheduler;
    localparam int FW  = 32;
    localparam int PW  = 10;
    localparam int GAP = 16;
`ifdef VLC_FRAME_CHECKSUM_EN
    localparam int CSUM = 1;
`else
    localparam int CSUM = 0;
`endif

    logic          clk, reset, enable, fifo_empty, fifo_r_en;
    logic          tx_valid, tx_ready, tx_sof, tx_eof, busy;
    logic [PW-1:0] fifo_data_num;
    logic [FW-1:0] fifo_d_out, tx_data;
    logic [15:0]   frame_cnt;

    vlc_frame_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .fifo_data_num (fifo_data_num),
        .fifo_empty    (fifo_empty),
        .fifo_d_out    (fifo_d_out),
        .fifo_r_en     (fifo_r_en),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx_sof        (tx_sof),
        .tx_eof        (tx_eof),
        .busy          (busy),
        .frame_cnt     (frame_cnt)
    );

    typedef struct packed {
        logic          sof;
        logic          eof;
        logic          is_pay;
        logic [FW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [FW-1:0] fifo_q[$];
    int            n_vec = 0, n_fail = 0;
    int            rd_total = 0, pay_total = 0, underrun = 0, occ_max = 0;
    int            cyc = 0, eof_cyc = 0, sof_cyc = 0, gap_checks = 0;
    logic          gap_check_en = 1'b0;
    logic          stall_pend = 1'b0;
    logic [FW-1:0] stall_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // FIFO model: registered read data, cleared by the shared reset.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q.delete();
            fifo_d_out <= '0;
            rd_total = 0;
        end else if (fifo_r_en) begin
            rd_total++;
            if (fifo_q.size() == 0) underrun++;
            else fifo_d_out <= fifo_q.pop_front();
        end
    end

    always @(negedge clk) begin
        fifo_data_num = PW'(fifo_q.size());
        fifo_empty    = (fifo_q.size() == 0);
    end

    // Monitor: compares every accepted word against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            pay_total  = 0;
            stall_pend = 1'b0;
        end else begin
            if (stall_pend)
                check("stall_hold", 64'({tx_valid, tx_data}), 64'({1'b1, stall_data}));
            stall_pend = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (rd_total - pay_total > occ_max) occ_max = rd_total - pay_total;
            if (tx_valid && tx_ready) begin
                check("sb_has_word", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("tx_word", 64'({tx_sof, tx_eof, tx_data}), 64'({e.sof, e.eof, e.data}));
                    if (e.is_pay) pay_total++;
                end
                if (tx_sof) begin
                    if (gap_check_en && gap_checks == 0) begin
                        check("frame_gap", 64'(cyc - eof_cyc - 1), 64'(GAP));
                        gap_checks++;
                    end
                    sof_cyc = cyc;
                end
                if (tx_eof) eof_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(FW'(first + i));
    endtask

    task automatic push_frame(input int first, input int n);
        exp_t          e;
        logic [FW-1:0] x;
        x = '0;
        e = '{sof: 1'b1, eof: 1'b0, is_pay: 1'b0, data: 32'h5555_5555};
        exp_q.push_back(e);
        e = '{sof: 1'b0, eof: 1'b0, is_pay: 1'b0, data: {8'hC3, 14'd0, PW'(n)}};
        exp_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            e = '{sof: 1'b0, eof: (i == n - 1) && (CSUM == 0), is_pay: 1'b1, data: FW'(first + i)};
            x ^= e.data;
            exp_q.push_back(e);
        end
        if (CSUM != 0) begin
            e = '{sof: 1'b0, eof: 1'b1, is_pay: 1'b0, data: x};
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_frames(input logic [15:0] target, input int budget);
        for (int i = 0; i < budget && frame_cnt != target; i++) tick();
        check("frame_cnt", 64'(frame_cnt), 64'(target));
    endtask

    initial begin
        int   base;
        logic saw;
        reset    = 1'b1;
        enable   = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("reset_outputs", 64'({fifo_r_en, tx_valid, tx_sof, tx_eof, busy, frame_cnt, tx_data}), 64'd0);
        reset = 1'b0;
        tick();

        // Full frame 1..64 with tx_ready held high.
        load(1, 64);
        push_frame(1, 64);
        repeat (3) tick();
        check("enable_gates_start", 64'({tx_valid, busy}), 64'd0);
        enable = 1'b1;
        tick();
        check("start_latency", 64'({tx_valid, tx_sof, tx_data}), 64'({2'b11, 32'h5555_5555}));
        wait_frames(16'd1, 300);
        check("rd_pulses", 64'(rd_total), 64'd64);
        check("frame_duration", 64'(eof_cyc - sof_cyc), 64'(67 + CSUM));

        // Short frame flushed by the timer.
        load(1, 10);
        push_frame(1, 10);
        saw = 1'b0;
        repeat (990) begin
            tick();
            if (tx_valid) saw = 1'b1;
        end
        check("flush_wait", 64'(saw), 64'd0);
        wait_frames(16'd2, 200);

        // Backpressure toggling every cycle.
        load(101, 64);
        push_frame(101, 64);
        for (int i = 0; i < 600 && frame_cnt != 16'd3; i++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b1;
        check("frame_cnt_toggle", 64'(frame_cnt), 64'd3);
        check("buffer_bound", 64'(occ_max <= 2), 64'd1);

        // Reset in PAY after 20 payload words.
        load(201, 64);
        push_frame(201, 64);
        base = pay_total;
        for (int i = 0; i < 200 && pay_total < base + 20; i++) tick();
        check("pay_before_reset", 64'(pay_total >= base + 20), 64'd1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("reset_midframe_outputs", 64'({fifo_r_en, tx_valid, tx_sof, tx_eof, busy, frame_cnt, tx_data}), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        load(1, 4);
        push_frame(1, 4);
        wait_frames(16'd1, 1300);

        // Two back-to-back full frames.
        load(401, 128);
        push_frame(401, 64);
        push_frame(465, 64);
        repeat (5) tick();
        gap_check_en = 1'b1;
        wait_frames(16'd3, 400);
        check("gap_checked", 64'(gap_checks), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("no_underrun", 64'(underrun), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
